// File: rtl/counter_pkg.sv
// Shared definitions for the binary_counter receive-side monitor.
//   - state_t : monitor FSM states
//   - step_t  : classification of one sample-to-sample step
//   - DIR_UP / DIR_DN : direction encoding, same as the counter's x input
//   - run_inc : saturating increment of the same-direction run length
package counter_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SYNC  = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    UP_STEP = 2'd0,
    DN_STEP = 2'd1,
    HOLD    = 2'd2,
    BAD     = 2'd3
  } step_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Run counter only needs to reach LOCK_N, whose legal range is 1..7.
  localparam int RUN_W = 3;

  // Increment the run length, never going past the lock threshold.
  function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] run,
                                                input logic [RUN_W-1:0] lim);
    logic [RUN_W-1:0] res;
    if (run >= lim) begin
      res = lim;
    end else begin
      res = run + 3'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/count_step_classify.sv
// Combinational step classifier.
//   prev : previously accepted counter value
//   cnt  : newly sampled counter value
//   step : UP_STEP (+1), DN_STEP (-1), HOLD (0) or BAD (anything else), mod 2^WIDTH
//   wrap : the step crossed the max/0 boundary in its own direction
module count_step_classify
  import counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cnt,
  output step_t            step,
  output logic             wrap
);

  logic [WIDTH-1:0] diff_s;

  // Modular difference between the new and the previous sample.
  assign diff_s = cnt - prev;

  // Map the difference onto a step code and detect boundary crossings.
  always_comb begin
    step = BAD;
    wrap = 1'b0;
    if (diff_s == {{(WIDTH-1){1'b0}}, 1'b1}) begin
      step = UP_STEP;
      wrap = (prev == {WIDTH{1'b1}}) && (cnt == {WIDTH{1'b0}});
    end else if (diff_s == {WIDTH{1'b1}}) begin
      step = DN_STEP;
      wrap = (prev == {WIDTH{1'b0}}) && (cnt == {WIDTH{1'b1}});
    end else if (diff_s == {WIDTH{1'b0}}) begin
      step = HOLD;
    end else begin
      step = BAD;
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Receive-side checker for an up/down binary counter.
//   clk, rst    : clock, synchronous active-high reset
//   valid, cnt  : sample qualifier and sampled counter value
//   dir         : recovered direction (0 up, 1 down)
//   locked      : direction confirmed by LOCK_N consecutive steps
//   err         : pulse on an illegal step; err_sticky holds it until reset
//   dir_chg     : pulse on an UP<->DOWN flip
//   wrap        : pulse on a max->0 / 0->max step; wrap_cnt counts them (saturating)
// All outputs are registered: one cycle of latency from the accepting edge.
module count_monitor
  import counter_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int LOCK_N = 2,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [WIDTH-1:0]  cnt,
  output logic              dir,
  output logic              locked,
  output logic              err,
  output logic              err_sticky,
  output logic              dir_chg,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_N);

  state_t            state_r, state_n;
  logic [WIDTH-1:0]  prev_r, prev_n;
  logic [RUN_W-1:0]  run_r, run_n;
  logic              dir_r, dir_n;
  logic              locked_r, locked_n;
  logic              err_r, err_n;
  logic              err_sticky_r, err_sticky_n;
  logic              dir_chg_r, dir_chg_n;
  logic              wrap_r, wrap_n;
  logic [WRAP_W-1:0] wrap_cnt_r, wrap_cnt_n;

  step_t             step_s;
  logic              wrap_s;

  count_step_classify #(.WIDTH(WIDTH)) u_classify (
    .prev (prev_r),
    .cnt  (cnt),
    .step (step_s),
    .wrap (wrap_s)
  );

  // Next-state, run-length and output computation for one sample.
  always_comb begin
    state_n      = state_r;
    prev_n       = prev_r;
    run_n        = run_r;
    dir_n        = dir_r;
    err_n        = 1'b0;
    err_sticky_n = err_sticky_r;
    dir_chg_n    = 1'b0;
    wrap_n       = 1'b0;
    wrap_cnt_n   = wrap_cnt_r;
    locked_n     = locked_r;

    if (valid) begin
      // Every accepted sample becomes the reference for the next one.
      prev_n = cnt;
      if (state_r == EMPTY) begin
        // First sample only seeds prev; no step exists yet.
        state_n = SYNC;
      end else begin
        wrap_n = wrap_s;
        if (wrap_s && (wrap_cnt_r != {WRAP_W{1'b1}})) begin
          wrap_cnt_n = wrap_cnt_r + WRAP_W'(1'b1);
        end else begin
          wrap_cnt_n = wrap_cnt_r;
        end

        case (step_s)
          UP_STEP: begin
            if (state_r == UP) begin
              run_n = run_inc(run_r, LOCK_V);
            end else begin
              dir_chg_n = (state_r == DOWN);
              state_n   = UP;
              dir_n     = DIR_UP;
              run_n     = 3'd1;
            end
          end
          DN_STEP: begin
            if (state_r == DOWN) begin
              run_n = run_inc(run_r, LOCK_V);
            end else begin
              dir_chg_n = (state_r == UP);
              state_n   = DOWN;
              dir_n     = DIR_DN;
              run_n     = 3'd1;
            end
          end
          HOLD: begin
            state_n = state_r;
          end
          default: begin
            // Illegal step: resynchronise but keep the last known direction.
            err_n        = 1'b1;
            err_sticky_n = 1'b1;
            state_n      = SYNC;
            run_n        = 3'd0;
          end
        endcase

        // A flip or error always drops lock, regardless of threshold.
        if (dir_chg_n || err_n) begin
          locked_n = 1'b0;
        end else begin
          locked_n = ((state_n == UP) || (state_n == DOWN)) && (run_n >= LOCK_V);
        end
      end
    end else begin
      state_n = state_r;
    end
  end

  // State and output registers; reset wins over any sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= EMPTY;
      prev_r       <= {WIDTH{1'b0}};
      run_r        <= 3'd0;
      dir_r        <= 1'b0;
      locked_r     <= 1'b0;
      err_r        <= 1'b0;
      err_sticky_r <= 1'b0;
      dir_chg_r    <= 1'b0;
      wrap_r       <= 1'b0;
      wrap_cnt_r   <= {WRAP_W{1'b0}};
    end else begin
      state_r      <= state_n;
      prev_r       <= prev_n;
      run_r        <= run_n;
      dir_r        <= dir_n;
      locked_r     <= locked_n;
      err_r        <= err_n;
      err_sticky_r <= err_sticky_n;
      dir_chg_r    <= dir_chg_n;
      wrap_r       <= wrap_n;
      wrap_cnt_r   <= wrap_cnt_n;
    end
  end

  assign dir        = dir_r;
  assign locked     = locked_r;
  assign err        = err_r;
  assign err_sticky = err_sticky_r;
  assign dir_chg    = dir_chg_r;
  assign wrap       = wrap_r;
  assign wrap_cnt   = wrap_cnt_r;

endmodule

// File: tb/tb_count_monitor.sv
// Scoreboard bench for count_monitor: a driver applies directed and random
// samples, a reference model predicts outputs and queues them, and a monitor
// compares DUT outputs one cycle after each edge. A second instance with a
// 2-bit wrap counter exercises saturation.
module tb_count_monitor;

  typedef struct {
    logic       dir;
    logic       locked;
    logic       err;
    logic       err_sticky;
    logic       dir_chg;
    logic       wrap;
    logic [7:0] wrap_cnt;
    logic [1:0] wrap_cnt2;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [2:0] cnt;

  logic       dir, locked, err, err_sticky, dir_chg, wrap;
  logic [7:0] wrap_cnt;
  logic       dir2, locked2, err2, err_sticky2, dir_chg2, wrap2;
  logic [1:0] wrap_cnt2;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: mode 0 = no sample yet, 1 = searching, 2 = up, 3 = down
  int   m_mode, m_prev, m_run, m_wraps;
  logic m_dir, m_locked, m_sticky;

  count_monitor dut (
    .clk(clk), .rst(rst), .valid(valid), .cnt(cnt),
    .dir(dir), .locked(locked), .err(err), .err_sticky(err_sticky),
    .dir_chg(dir_chg), .wrap(wrap), .wrap_cnt(wrap_cnt)
  );

  count_monitor #(.WRAP_W(2)) dut2 (
    .clk(clk), .rst(rst), .valid(valid), .cnt(cnt),
    .dir(dir2), .locked(locked2), .err(err2), .err_sticky(err_sticky2),
    .dir_chg(dir_chg2), .wrap(wrap2), .wrap_cnt(wrap_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Predict the outputs seen after the coming edge and advance the model.
  task automatic model(input logic r, input logic v, input int c);
    exp_t e;
    int   d;
    e.err = 1'b0; e.dir_chg = 1'b0; e.wrap = 1'b0;
    if (r) begin
      m_mode = 0; m_prev = 0; m_run = 0; m_wraps = 0;
      m_dir = 1'b0; m_locked = 1'b0; m_sticky = 1'b0;
    end else if (v) begin
      if (m_mode == 0) begin
        m_mode = 1;
      end else begin
        d = (c - m_prev) & 7;
        if ((d == 1 && c == 0) || (d == 7 && c == 7)) begin
          e.wrap = 1'b1;
          m_wraps++;
        end
        if (d == 1 || d == 7) begin
          if (m_mode == (d == 1 ? 2 : 3)) begin
            m_run = (m_run + 1 > 2) ? 2 : m_run + 1;
          end else begin
            e.dir_chg = (m_mode == (d == 1 ? 3 : 2));
            m_mode = (d == 1) ? 2 : 3;
            m_dir  = (d == 7);
            m_run  = 1;
          end
        end else if (d != 0) begin
          e.err = 1'b1;
          m_sticky = 1'b1;
          m_mode = 1;
          m_run = 0;
        end
        m_locked = (m_mode >= 2) && (m_run >= 2);
      end
      m_prev = c;
    end
    e.dir = m_dir;
    e.locked = m_locked;
    e.err_sticky = m_sticky;
    e.wrap_cnt = (m_wraps > 255) ? 8'd255 : 8'(m_wraps);
    e.wrap_cnt2 = (m_wraps > 3) ? 2'd3 : 2'(m_wraps);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic v, input int c);
    @(negedge clk);
    rst = r;
    valid = v;
    cnt = 3'(c);
    model(r, v, c);
  endtask

  task automatic sample(input int c);
    drive(1'b0, 1'b1, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, $urandom_range(0, 7));
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 0);
  endtask

  // Monitor: compare every registered output against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dir", dir, e.dir);
        chk("locked", locked, e.locked);
        chk("err", err, e.err);
        chk("err_sticky", err_sticky, e.err_sticky);
        chk("dir_chg", dir_chg, e.dir_chg);
        chk("wrap", wrap, e.wrap);
        chk("wrap_cnt", wrap_cnt, e.wrap_cnt);
        chk("wrap_cnt_w2", wrap_cnt2, e.wrap_cnt2);
        chk("locked_w2", locked2, e.locked);
        chk("err_w2", err2, e.err);
      end
    end
  end

  initial begin
    int cur;
    int r;
    rst = 1'b1; valid = 1'b0; cnt = 3'd0;
    m_mode = 0; m_prev = 0; m_run = 0; m_wraps = 0;
    m_dir = 1'b0; m_locked = 1'b0; m_sticky = 1'b0;

    do_reset(); do_reset();
    // Up-count with lock and wrap
    for (int i = 0; i < 10; i++) sample(i % 8);
    // Direction flip
    do_reset();
    sample(3); sample(4); sample(5); sample(4); sample(3); sample(2);
    // Illegal step
    do_reset();
    sample(1); sample(2); sample(3); sample(6); sample(7);
    // Hold and gaps
    do_reset();
    sample(2); idle(3); sample(2); idle(3); sample(2); sample(3);
    // Down wrap and saturation
    do_reset();
    sample(0);
    for (int k = 0; k < 5; k++)
      for (int v = 7; v >= 0; v--) sample(v);
    do_reset();
    sample(0); sample(7);
    // Reset mid-run with valid on the same edge
    do_reset();
    sample(0); sample(1); sample(2); sample(3); sample(6);
    sample(7); sample(0); sample(1);
    drive(1'b1, 1'b1, 4);
    sample(5); sample(6);

    // Randomised run: mostly legal steps with holds, gaps, glitches and resets
    cur = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 2) begin
        do_reset();
      end else if (r < 80) begin
        cur = (cur + 1) & 7; sample(cur);
      end else if (r < 150) begin
        cur = (cur + 7) & 7; sample(cur);
      end else if (r < 170) begin
        sample(cur);
      end else if (r < 182) begin
        cur = $urandom_range(0, 7); sample(cur);
      end else begin
        idle(1);
      end
    end

    idle(2);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
